// File: rtl/regfile_sb.sv
// Integer register file for the pipelined core. It has two combinational read ports, one write
// port, optional write-to-read bypass, and a per-register busy scoreboard used for hazard stalls.
module regfile_sb #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  localparam int             AW       = $clog2(NREGS),
  parameter int              SP_INDEX = 2,
  parameter logic [XLEN-1:0] SP_RESET = 32'h0000001F,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] ruRs1,
  output logic [XLEN-1:0] ruRs2,
  input  logic            ruWr,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] DataWr,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_accept,
  output logic            stall,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     busy_count,
  output logic            wb_err
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      count_next;
  logic             waw;

  // NOTE: the architectural state is reset in full, because software depends on x0..xN
  // starting at known values. This is why the array is a bank of flops and not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= (r == SP_INDEX) ? SP_RESET : '0;
    end else if (ruWr && rd != '0) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      regs[rd] <= DataWr;
    end
  end

  // Per-register writeback hit. This vector is shared by the bypass, the busy flags, and the
  // busy-bit clear logic.
  always_comb begin
    // NOTE: a default assignment comes first so that every path drives the vector and no latch is inferred.
    wb_clr = '0;
    for (int r = 1; r < NREGS; r++)
      wb_clr[r] = ruWr && (rd == AW'(r));
  end

  always_comb begin
    ruRs1 = '0;
    ruRs2 = '0;
    if (rs1 != '0) ruRs1 = (BYPASS && wb_clr[rs1]) ? DataWr : regs[rs1];
    if (rs2 != '0) ruRs2 = (BYPASS && wb_clr[rs2]) ? DataWr : regs[rs2];
  end

  assign rs1_busy     = busy[rs1] && !(BYPASS && wb_clr[rs1]);
  assign rs2_busy     = busy[rs2] && !(BYPASS && wb_clr[rs2]);
  assign waw          = (issue_rd != '0) && busy[issue_rd] && !wb_clr[issue_rd];
  assign stall        = issue_valid && (rs1_busy || rs2_busy || waw);
  assign issue_accept = issue_valid && !stall;

  // When a new reservation and a writeback hit the same register, the reservation is kept,
  // because it belongs to the younger producer.
  always_comb begin
    busy_next  = busy;
    count_next = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_accept && issue_rd == AW'(r)) busy_next[r] = 1'b1;
      else if (wb_clr[r])                     busy_next[r] = 1'b0;
    end
    busy_next[0] = 1'b0;
    for (int r = 0; r < NREGS; r++)
      count_next = count_next + (AW+1)'(busy_next[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
      if (ruWr && rd != '0 && !busy[rd]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb. It checks a bypassing instance against hand-computed values and
// uses a non-bypassing twin for the forwarding cases.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   rs1 = '0, rs2 = '0, rd = '0, issue_rd = '0;
  logic            ruWr = 1'b0, issue_valid = 1'b0;
  logic [XLEN-1:0] DataWr = '0;

  logic [XLEN-1:0] ruRs1, ruRs2, nb_ruRs1, nb_ruRs2;
  logic            issue_accept, stall, rs1_busy, rs2_busy, wb_err;
  logic            nb_issue_accept, nb_stall, nb_rs1_busy, nb_rs2_busy, nb_wb_err;
  logic [AW:0]     busy_count, nb_busy_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ruRs1(ruRs1), .ruRs2(ruRs2),
    .ruWr(ruWr), .rd(rd), .DataWr(DataWr), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_accept(issue_accept), .stall(stall), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_count(busy_count), .wb_err(wb_err)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ruRs1(nb_ruRs1), .ruRs2(nb_ruRs2),
    .ruWr(ruWr), .rd(rd), .DataWr(DataWr), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_accept(nb_issue_accept), .stall(nb_stall), .rs1_busy(nb_rs1_busy),
    .rs2_busy(nb_rs2_busy), .busy_count(nb_busy_count), .wb_err(nb_wb_err)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ruWr = 1'b0; issue_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; issue_rd = '0; DataWr = '0;
  endtask

  initial begin
    // Reset values
    #12;
    @(negedge clk) rst = 1'b0;
    rs1 = 5'd2; rs2 = 5'd0; #1;
    check("rst_x2", ruRs1, 32'h1F);
    check("rst_x0", ruRs2, 32'h0);
    rs1 = 5'd1; rs2 = 5'd31; #1;
    check("rst_x1", ruRs1, 32'h0);
    check("rst_x31", ruRs2, 32'h0);
    check("rst_count", 32'(busy_count), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    issue_valid = 1'b1; rs1 = '0; rs2 = '0; #1;
    check("rst_accept_x0", 32'(issue_accept), 32'd1);
    tick();

    // Bypass: reserve x5, then write it while reading it back
    idle(); issue_valid = 1'b1; issue_rd = 5'd5; tick();
    idle(); ruWr = 1'b1; rd = 5'd5; DataWr = 32'hDEADBEEF; rs1 = 5'd5; #1;
    check("byp_data", ruRs1, 32'hDEADBEEF);
    check("nobyp_data", nb_ruRs1, 32'h0);
    check("byp_busy", 32'(rs1_busy), 32'd0);
    check("nobyp_busy", 32'(nb_rs1_busy), 32'd1);
    tick();
    ruWr = 1'b0; #1;
    check("byp_after", ruRs1, 32'hDEADBEEF);
    check("nobyp_after", nb_ruRs1, 32'hDEADBEEF);
    check("byp_count", 32'(busy_count), 32'd0);
    check("byp_wb_err", 32'(wb_err), 32'd0);

    // RAW stall on x7
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; #1;
    check("raw_reserve", 32'(issue_accept), 32'd1);
    tick();
    issue_rd = 5'd8; rs2 = 5'd7; #1;
    check("raw_stall", 32'(stall), 32'd1);
    check("raw_accept", 32'(issue_accept), 32'd0);
    check("raw_rs2_busy", 32'(rs2_busy), 32'd1);
    tick();
    check("raw_hold_count", 32'(busy_count), 32'd1);
    ruWr = 1'b1; rd = 5'd7; DataWr = 32'h42; #1;
    check("raw_release_stall", 32'(stall), 32'd0);
    check("raw_release_data", ruRs2, 32'h42);
    check("raw_release_accept", 32'(issue_accept), 32'd1);
    check("raw_nobyp_stall", 32'(nb_stall), 32'd1);
    tick();
    check("raw_x8_count", 32'(busy_count), 32'd1);
    idle(); ruWr = 1'b1; rd = 5'd8; tick();
    check("raw_clear_count", 32'(busy_count), 32'd0);

    // WAW and a simultaneous release plus re-reserve of x9
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; tick();
    check("waw_count1", 32'(busy_count), 32'd1);
    #1;
    check("waw_stall", 32'(stall), 32'd1);
    ruWr = 1'b1; rd = 5'd9; DataWr = 32'h99; #1;
    check("waw_same_accept", 32'(issue_accept), 32'd1);
    tick();
    check("waw_same_count", 32'(busy_count), 32'd1);
    check("waw_same_wb_err", 32'(wb_err), 32'd0);
    issue_valid = 1'b0; tick();
    check("waw_free_count", 32'(busy_count), 32'd0);
    check("waw_free_wb_err", 32'(wb_err), 32'd0);

    // Fill x1..x31, then exercise x0 and the sticky error flag
    idle();
    for (int i = 1; i < 32; i++) begin
      issue_valid = 1'b1; issue_rd = AW'(i); tick();
    end
    check("fill_count", 32'(busy_count), 32'd31);
    issue_rd = 5'd0; #1;
    check("fill_x0_accept", 32'(issue_accept), 32'd1);
    tick();
    check("fill_x0_count", 32'(busy_count), 32'd31);
    idle(); ruWr = 1'b1; rd = 5'd0; DataWr = 32'hFFFFFFFF; tick();
    ruWr = 1'b0; #1;
    check("x0_read", ruRs1, 32'h0);
    check("x0_count", 32'(busy_count), 32'd31);
    check("x0_wb_err", 32'(wb_err), 32'd0);
    ruWr = 1'b1; rd = 5'd3; DataWr = 32'h3; tick();
    check("x3_free_count", 32'(busy_count), 32'd30);
    check("x3_free_wb_err", 32'(wb_err), 32'd0);
    DataWr = 32'h33; tick();
    check("x3_err_set", 32'(wb_err), 32'd1);
    ruWr = 1'b0; rs1 = 5'd3; tick();
    check("x3_err_sticky", 32'(wb_err), 32'd1);
    check("x3_err_write", ruRs1, 32'h33);

    // Mid-cycle reset clears the sticky error
    #2 rst = 1'b1; #1;
    check("rst1_wb_err", 32'(wb_err), 32'd0);
    check("rst1_count", 32'(busy_count), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Ten busy registers, then an asynchronous reset between edges
    idle();
    for (int i = 1; i <= 11; i++) begin
      issue_valid = 1'b1; issue_rd = AW'(i); tick();
    end
    idle(); ruWr = 1'b1; rd = 5'd2; DataWr = 32'h55; tick();
    ruWr = 1'b0; rs1 = 5'd2; #1;
    check("pre_rst_count", 32'(busy_count), 32'd10);
    check("pre_rst_x2", ruRs1, 32'h55);
    issue_valid = 1'b1; issue_rd = 5'd20; rs1 = 5'd5; #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #1 rst = 1'b1; #1;
    check("async_count", 32'(busy_count), 32'd0);
    check("async_stall", 32'(stall), 32'd0);
    @(negedge clk) rst = 1'b0;
    idle(); rs1 = 5'd2; #1;
    check("post_rst_x2", ruRs1, 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
